// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM encoding and access constants for the data-memory controller
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic {LOAD, STORE} access_t;
    localparam int OFFSET_W = 3;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word RAM, synchronous write and combinational read
module dmem_array #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              Clk,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] Index,
    input  logic [63:0]       WrData,
    output logic [63:0]       RdData
);
    logic [63:0] mem [DEPTH];
    always_ff @(posedge Clk)
        if (WrEn) mem[Index] <= WrData;
    assign RdData = mem[Index];
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle LDUR/STUR controller with valid/ready requests and a one-cycle response pulse
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        Clk,
    input  logic        ResetL,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [63:0] Address,
    input  logic [63:0] WriteData,
    output logic        RespValid,
    output logic [63:0] ReadData,
    output logic        Fault,
    output logic        Stall
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = LATENCY > 1 ? $clog2(LATENCY) : 1;
    state_t            state, state_nx;
    access_t           op_q;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] idx_q;
    logic [63:0]       wdata_q, rd_data;
    logic              valid_req, access, wr_en;
    // Bits above the array range must be zero: no wrap-around of large addresses.
    assign valid_req = (MemRead ^ MemWrite) && Address[OFFSET_W-1:0] == '0
                       && Address[63:ADDR_W+OFFSET_W] == '0;
    assign access = state == WAIT && cnt == '0;
    assign wr_en  = access && op_q == STORE;
    always_comb begin
        state_nx  = state;
        ReqReady  = state == IDLE;
        RespValid = state == RESP;
        Stall     = state == WAIT || (state == IDLE && ReqValid);
        state_nx  = state == IDLE ? (ReqValid ? (valid_req ? WAIT : RESP) : IDLE)
                  : state == WAIT ? (access ? RESP : WAIT)
                  : IDLE;
    end
    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            state    <= IDLE;
            op_q     <= LOAD;
            cnt      <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
            ReadData <= '0;
            Fault    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && ReqValid) begin
                idx_q   <= Address[ADDR_W+OFFSET_W-1:OFFSET_W];
                wdata_q <= WriteData;
                op_q    <= MemWrite ? STORE : LOAD;
                cnt     <= CNT_W'(LATENCY - 1);
                if (!valid_req) begin
                    Fault    <= 1'b1;
                    ReadData <= '0;
                end
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (access) begin
                Fault <= 1'b0;
                if (op_q == LOAD) ReadData <= rd_data;
            end
        end
    end
    dmem_array #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_array (
        .Clk   (Clk),
        .WrEn  (wr_en),
        .Index (idx_q),
        .WrData(wdata_q),
        .RdData(rd_data)
    );
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench with a word-array reference model for dmem_ctrl
module tb_dmem_ctrl;
    localparam int DEPTH = 64;
    localparam int LAT   = 2;
    typedef struct {
        logic        fault;
        logic [63:0] data;
        int          when;
    } exp_t;
    logic        Clk = 1'b0, ResetL = 1'b0, ReqValid = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
    logic [63:0] Address = '0, WriteData = '0;
    logic        ReqReady, RespValid, Fault, Stall;
    logic [63:0] ReadData;
    logic [63:0] mdl [DEPTH];
    logic [63:0] last_rd = '0;
    exp_t        q[$];
    int          cyc = 0, checks = 0, errors = 0;
    int          busy_from = 1, busy_to = 0;
    dmem_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .Clk(Clk), .ResetL(ResetL), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address), .WriteData(WriteData),
        .RespValid(RespValid), .ReadData(ReadData), .Fault(Fault), .Stall(Stall)
    );
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask
    always @(negedge Clk) begin
        if (ResetL && RespValid) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_cycle", 64'(cyc), 64'(e.when));
                chk("resp_fault", {63'd0, Fault}, {63'd0, e.fault});
                chk("resp_data", ReadData, e.data);
            end
        end
    end
    task automatic send(input logic rd, input logic wr, input logic [63:0] a,
                        input logic [63:0] d, output int acc);
        exp_t e;
        int   ix;
        bit   ok;
        ReqValid = 1'b1; MemRead = rd; MemWrite = wr; Address = a; WriteData = d;
        for (int n = 0; n < 30; n++) begin
            #1;
            if (cyc >= busy_from && cyc <= busy_to) begin
                chk("busy_ready", {63'd0, ReqReady}, 64'd0);
                chk("busy_stall", {63'd0, Stall}, 64'd1);
            end
            if (ReqReady) break;
            @(negedge Clk);
        end
        if (!ReqReady) begin
            chk("ready_timeout", 64'd0, 64'd1);
            ReqValid = 1'b0;
            acc = -1;
            return;
        end
        chk("idle_req_stall", {63'd0, Stall}, 64'd1);
        acc = cyc + 1;
        ok  = (rd != wr) && a[2:0] == 3'd0 && a < 64'(DEPTH * 8);
        ix  = int'(a >> 3) % DEPTH;
        if (!ok) begin
            last_rd = '0;
            e = '{fault: 1'b1, data: 64'd0, when: acc};
            busy_from = 1; busy_to = 0;
        end else begin
            if (wr) mdl[ix] = d;
            else last_rd = mdl[ix];
            e = '{fault: 1'b0, data: last_rd, when: acc + LAT};
            busy_from = acc; busy_to = acc + LAT - 1;
        end
        q.push_back(e);
        @(posedge Clk);
        #1 ReqValid = 1'b0;
    endtask
    task automatic check_reset_outputs(input string tag);
        chk({tag, "_respvalid"}, {63'd0, RespValid}, 64'd0);
        chk({tag, "_readdata"}, ReadData, 64'd0);
        chk({tag, "_fault"}, {63'd0, Fault}, 64'd0);
        chk({tag, "_reqready"}, {63'd0, ReqReady}, 64'd1);
        chk({tag, "_stall"}, {63'd0, Stall}, 64'd0);
    endtask
    initial begin
        int a0, a1, k;
        logic [63:0] old, a, d;
        #23 check_reset_outputs("reset");
        @(negedge Clk) ResetL = 1'b1;
        for (int i = 0; i < DEPTH; i++) send(1'b0, 1'b1, 64'(i * 8), {$urandom, $urandom}, a0);
        send(1'b0, 1'b1, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, a0);
        send(1'b1, 1'b0, 64'h10, 64'h0, a0);
        send(1'b1, 1'b0, 64'h0C, 64'h0, a0);
        send(1'b1, 1'b0, 64'h08, 64'h0, a0);
        send(1'b1, 1'b0, 64'h200, 64'h0, a0);
        send(1'b1, 1'b1, 64'h18, 64'h1234, a0);
        send(1'b1, 1'b0, 64'h18, 64'h0, a0);
        send(1'b0, 1'b0, 64'h20, 64'h0, a0);
        send(1'b0, 1'b1, 64'h20, 64'hA5A5_0000_FFFF_0001, a0);
        send(1'b1, 1'b0, 64'h20, 64'h0, a1);
        chk("b2b_gap", 64'(a1 - a0), 64'(LAT + 2));
        send(1'b0, 1'b1, 64'h18, 64'h1, a0);
        send(1'b1, 1'b0, 64'h10, 64'h0, a0);
        repeat (4) @(negedge Clk);
        old = mdl[3];
        send(1'b0, 1'b1, 64'h18, 64'h5, a0);
        #2 ResetL = 1'b0;
        #1 check_reset_outputs("midwait_reset");
        mdl[3] = old;
        last_rd = '0;
        q.delete();
        repeat (3) @(negedge Clk);
        ResetL = 1'b1;
        send(1'b1, 1'b0, 64'h18, 64'h0, a0);
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 9);
            a = 64'($urandom_range(0, DEPTH - 1)) << 3;
            d = {$urandom, $urandom};
            if (k == 0) send(1'b1, 1'b0, a | 64'($urandom_range(1, 7)), d, a0);
            else if (k == 1) send(1'b1, 1'b0, a | (64'd1 << $urandom_range(9, 63)), d, a0);
            else if (k == 2) begin
                logic b;
                b = 1'($urandom);
                send(b, b, a, d, a0);
            end else send(1'(k % 2), 1'(~(k % 2)), a, d, a0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge Clk);
        end
        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge Clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
